// File: rtl/cmd_dispatcher.sv
// Command queue in front of the serializer: buffers legal {addr,cmd} requests,
// drops illegal addresses, and issues one strobe per busy handshake.
module cmd_dispatcher #(
  parameter int DEPTH        = 8,
  parameter int NUM_OBJ      = 18,
  parameter int BUSY_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [4:0]               cmd_addr_i,
  input  logic                     cmd_i,
  input  logic                     cmd_val_i,
  output logic                     cmd_rdy_o,
  input  logic                     busy_i,
  output logic [5:0]               data_o,
  output logic                     data_val_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     timeout_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [4:0]       MAX_ADDR = 5'(NUM_OBJ);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);

  typedef struct packed {
    logic [4:0] addr;
    logic       cmd;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  req_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic [CNT_W-1:0] drop_q,   drop_d;
  state_e           state_q,  state_d;
  req_t             data_q,   data_d;
  logic             dval_q,   dval_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             to_q,     to_d;

  logic accept, legal, push, pop;

  // ---------------------------------------------------------------- input side
  assign cmd_rdy_o = (level_q != FULL_LVL);
  assign accept    = cmd_val_i && cmd_rdy_o;
  assign legal     = (cmd_addr_i != 5'd0) && (cmd_addr_i <= MAX_ADDR);
  assign push      = accept && legal;

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= req_t'{addr: cmd_addr_i, cmd: cmd_i};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // Saturate so a flood of bad requests cannot wrap the counter to a small value.
    if (accept && !legal && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  // ---------------------------------------------------------------- launch FSM
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dval_d   = 1'b0;
    to_cnt_d = to_cnt_q;
    to_d     = to_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((level_q != '0) && !busy_i) begin
          pop     = 1'b1;
          data_d  = fifo_mem[rd_ptr_q];
          dval_d  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        to_cnt_d = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy_i) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      state_q  <= IDLE;
      data_q   <= '0;
      dval_q   <= 1'b0;
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
      data_q   <= data_d;
      dval_q   <= dval_d;
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
    end
  end

  assign data_o     = data_q;
  assign data_val_o = dval_q;
  assign level_o    = level_q;
  assign drop_cnt_o = drop_q;
  assign timeout_o  = to_q;

endmodule
